disassembler: RTL and testbench



---
 rtl/pmp_assemble_pkg.sv | 9 +
 rtl/disassembler.sv | 155 +++++++++++++++
 tb/tb_disassembler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pmp_assemble_pkg.sv
// Shared defaults and FSM encoding for the disassembler and its assembler peer.
package pmp_assemble_pkg;
  localparam int DATA_WIDTH_DEF   = 16;
  localparam int TAG_WIDTH_DEF    = 8;
  localparam int TAG_CATAGORY_DEF = 4;
  localparam int DROP_CNT_W       = 16;

  typedef enum logic {COLLECT = 1'b0, PEND = 1'b1} dis_state_e;
endpackage

// File: rtl/disassembler.sv
// Scatters tagged beats into lanes, emitting each lane group as one wide masked beat.
module disassembler
  import pmp_assemble_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int TAG_WIDTH    = TAG_WIDTH_DEF,
  parameter int TAG_CATAGORY = TAG_CATAGORY_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DATA_WIDTH-1:0]                    data_i,
  input  logic [TAG_WIDTH-1:0]                     tag_i,
  input  logic                                     tlast_i,
  input  logic                                     vld_i,
  output logic                                     rdy_o,
  output logic [TAG_CATAGORY-1:0][DATA_WIDTH-1:0]  data_o,
  output logic [TAG_CATAGORY-1:0]                  mask_o,
  output logic                                     tlast_o,
  output logic                                     vld_o,
  input  logic                                     rdy_i,
  output logic [DROP_CNT_W-1:0]                    drop_cnt_o
);
  typedef logic [TAG_CATAGORY-1:0][DATA_WIDTH-1:0] lanes_t;

  dis_state_e              r_state, w_state_nxt;
  lanes_t                  r_acc_data, w_acc_data_nxt;
  logic [TAG_CATAGORY-1:0] r_acc_mask, w_acc_mask_nxt;
  logic                    r_pend_last, w_pend_last_nxt;

  lanes_t                  r_data_o;
  logic [TAG_CATAGORY-1:0] r_mask_o;
  logic                    r_tlast_o, r_vld_o;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;

  logic                    w_out_free, w_accept, w_in_range, w_collide, w_drop;
  logic [TAG_CATAGORY-1:0] w_onehot, w_merged_mask;
  lanes_t                  w_merged_data, w_single_data;
  logic                    w_flush, w_flush_last;
  lanes_t                  w_flush_data;
  logic [TAG_CATAGORY-1:0] w_flush_mask;

  assign w_out_free = ~r_vld_o | rdy_i;
  assign rdy_o      = (r_state == COLLECT) & w_out_free;
  assign w_accept   = vld_i & rdy_o;

  // Lane decode as a one-hot; an all-zero vector means the tag is out of range.
  always_comb begin
    w_onehot      = '0;
    w_merged_data = r_acc_data;
    w_single_data = '0;
    for (int i = 0; i < TAG_CATAGORY; i++) begin
      if (tag_i == TAG_WIDTH'(i)) begin
        w_onehot[i]      = 1'b1;
        w_merged_data[i] = data_i;
        w_single_data[i] = data_i;
      end
    end
  end

  assign w_in_range    = |w_onehot;
  assign w_collide     = |(w_onehot & r_acc_mask);
  assign w_merged_mask = r_acc_mask | w_onehot;
  assign w_drop        = w_accept & ~w_in_range;

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_data_nxt  = r_acc_data;
    w_acc_mask_nxt  = r_acc_mask;
    w_pend_last_nxt = r_pend_last;
    w_flush         = 1'b0;
    w_flush_data    = r_acc_data;
    w_flush_mask    = r_acc_mask;
    w_flush_last    = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (!w_in_range) begin
            if (tlast_i && (r_acc_mask != '0)) begin
              w_flush        = 1'b1;
              w_flush_last   = 1'b1;
              w_acc_data_nxt = '0;
              w_acc_mask_nxt = '0;
            end
          end else if (!w_collide) begin
            if ((&w_merged_mask) || tlast_i) begin
              w_flush        = 1'b1;
              w_flush_data   = w_merged_data;
              w_flush_mask   = w_merged_mask;
              w_flush_last   = tlast_i;
              w_acc_data_nxt = '0;
              w_acc_mask_nxt = '0;
            end else begin
              w_acc_data_nxt = w_merged_data;
              w_acc_mask_nxt = w_merged_mask;
            end
          end else begin
            // Old group leaves now; the colliding beat starts a fresh group.
            w_flush        = 1'b1;
            w_acc_data_nxt = w_single_data;
            w_acc_mask_nxt = w_onehot;
            if (tlast_i || (&w_onehot)) begin
              w_state_nxt     = PEND;
              w_pend_last_nxt = tlast_i;
            end
          end
        end
      end
      PEND: begin
        if (w_out_free) begin
          w_flush        = 1'b1;
          w_flush_last   = r_pend_last;
          w_acc_data_nxt = '0;
          w_acc_mask_nxt = '0;
          w_state_nxt    = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_acc_data  <= '0;
      r_acc_mask  <= '0;
      r_pend_last <= 1'b0;
      r_data_o    <= '0;
      r_mask_o    <= '0;
      r_tlast_o   <= 1'b0;
      r_vld_o     <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_data  <= w_acc_data_nxt;
      r_acc_mask  <= w_acc_mask_nxt;
      r_pend_last <= w_pend_last_nxt;
      if (w_flush) begin
        r_data_o  <= w_flush_data;
        r_mask_o  <= w_flush_mask;
        r_tlast_o <= w_flush_last;
        r_vld_o   <= 1'b1;
      end else if (r_vld_o && rdy_i) begin
        r_vld_o   <= 1'b0;
      end
      if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}}))
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign data_o     = r_data_o;
  assign mask_o     = r_mask_o;
  assign tlast_o    = r_tlast_o;
  assign vld_o      = r_vld_o;
  assign drop_cnt_o = r_drop_cnt;
endmodule

// File: tb/tb_disassembler.sv
// Directed bench for disassembler: grouping, collisions, drops, backpressure, reset.
module tb_disassembler;
  localparam int DW = 16;
  localparam int TW = 8;
  localparam int N  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [DW-1:0]        data_i = '0;
  logic [TW-1:0]        tag_i = '0;
  logic                 tlast_i = 1'b0;
  logic                 vld_i = 1'b0;
  logic                 rdy_o;
  logic [N-1:0][DW-1:0] data_o;
  logic [N-1:0]         mask_o;
  logic                 tlast_o;
  logic                 vld_o;
  logic                 rdy_i = 1'b1;
  logic [15:0]          drop_cnt_o;

  disassembler #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .TAG_CATAGORY(N)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .tag_i(tag_i), .tlast_i(tlast_i),
    .vld_i(vld_i), .rdy_o(rdy_o), .data_o(data_o), .mask_o(mask_o),
    .tlast_o(tlast_o), .vld_o(vld_o), .rdy_i(rdy_i), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][DW-1:0] d;
    logic [N-1:0]         m;
    logic                 l;
    int                   cyc;
  } xfer_t;

  xfer_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  // Outputs are sampled just after the falling edge; a transfer is logged when
  // the coming rising edge will complete the handshake.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst_n && vld_o && rdy_i) q.push_back('{d: data_o, m: mask_o, l: tlast_o, cyc: cyc});
  end

  // Entered and left at a falling edge; the beat is taken on the rising edge in between.
  task automatic send(input logic [TW-1:0] t, input logic [DW-1:0] d, input logic l);
    int n = 0;
    vld_i = 1'b1; tag_i = t; data_i = d; tlast_i = l;
    #1;
    while (!rdy_o && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL send_timeout tag=%0d rdy_o stuck low", t); end
    @(negedge clk);
    vld_i = 1'b0; tlast_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy_i = 1'b1;
    idle(3);
    #2;
    checks++;
    if ({vld_o, mask_o, tlast_o} !== 6'b0 || data_o !== '0 || drop_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_outputs vld=%b mask=%b last=%b data=%h drop=%0d expected all 0",
                         vld_o, mask_o, tlast_o, data_o, drop_cnt_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy rdy_o=%b expected 1", rdy_o); end
    @(negedge clk);
    q.delete();
  endtask

  task automatic test_four_beats();
    q.delete();
    for (int i = 0; i < 4; i++) send(TW'(i), DW'(16'hA0 + i), i == 3);
    #2;
    checks++;
    if (vld_o !== 1'b1) begin errors++; $display("FAIL four_latency vld_o=%b expected 1", vld_o); end
    idle(3);
    checks++;
    if (q.size() != 1) begin errors++; $display("FAIL four_count got %0d expected 1", q.size()); end
    else begin
      checks++;
      if (q[0].d !== {16'hA3, 16'hA2, 16'hA1, 16'hA0} || q[0].m !== 4'b1111 || q[0].l !== 1'b1) begin
        errors++; $display("FAIL four_data data=%h mask=%b last=%b expected 00a300a200a100a0 1111 1",
                           q[0].d, q[0].m, q[0].l);
      end
    end
  endtask

  task automatic test_collision();
    q.delete();
    send(0, 16'h11, 0); send(2, 16'h22, 0); send(0, 16'h33, 0);
    idle(2);
    checks++;
    if (q.size() != 1) begin errors++; $display("FAIL coll_count1 got %0d expected 1", q.size()); end
    else begin
      checks++;
      if (q[0].d !== {16'h0, 16'h22, 16'h0, 16'h11} || q[0].m !== 4'b0101 || q[0].l !== 1'b0) begin
        errors++; $display("FAIL coll_first data=%h mask=%b last=%b expected 0000002200000011 0101 0",
                           q[0].d, q[0].m, q[0].l);
      end
    end
    send(1, 16'h44, 1);
    idle(2);
    checks++;
    if (q.size() != 2) begin errors++; $display("FAIL coll_count2 got %0d expected 2", q.size()); end
    else begin
      checks++;
      if (q[1].d !== {16'h0, 16'h0, 16'h44, 16'h33} || q[1].m !== 4'b0011 || q[1].l !== 1'b1) begin
        errors++; $display("FAIL coll_second data=%h mask=%b last=%b expected 0000000000440033 0011 1",
                           q[1].d, q[1].m, q[1].l);
      end
    end
  endtask

  task automatic test_collision_last();
    int lo = 0;
    q.delete();
    send(1, 16'h61, 0);
    send(1, 16'h62, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (!rdy_o) lo++;
      @(negedge clk);
    end
    checks++;
    if (lo != 1) begin errors++; $display("FAIL colllast_rdy_low got %0d cycles expected 1", lo); end
    checks++;
    if (q.size() != 2) begin errors++; $display("FAIL colllast_count got %0d expected 2", q.size()); end
    else begin
      checks++;
      if (q[0].m !== 4'b0010 || q[0].l !== 1'b0 || q[0].d[1] !== 16'h61 ||
          q[1].m !== 4'b0010 || q[1].l !== 1'b1 || q[1].d[1] !== 16'h62) begin
        errors++; $display("FAIL colllast_data m0=%b l0=%b d0=%h m1=%b l1=%b d1=%h expected 0010 0 61 0010 1 62",
                           q[0].m, q[0].l, q[0].d[1], q[1].m, q[1].l, q[1].d[1]);
      end
      checks++;
      if (q[1].cyc - q[0].cyc != 1) begin
        errors++; $display("FAIL colllast_spacing got %0d cycles expected 1", q[1].cyc - q[0].cyc);
      end
    end
  endtask

  task automatic test_drop();
    logic [15:0] d0;
    q.delete();
    d0 = drop_cnt_o;
    send(1, 16'h55, 0);
    send(9, 16'h99, 1);
    idle(2);
    checks++;
    if (drop_cnt_o !== d0 + 16'd1) begin errors++; $display("FAIL drop_cnt got %0d expected %0d", drop_cnt_o, d0 + 1); end
    checks++;
    if (q.size() != 1) begin errors++; $display("FAIL drop_count got %0d expected 1", q.size()); end
    else begin
      checks++;
      if (q[0].d !== {16'h0, 16'h0, 16'h55, 16'h0} || q[0].m !== 4'b0010 || q[0].l !== 1'b1) begin
        errors++; $display("FAIL drop_flush data=%h mask=%b last=%b expected 0000000000550000 0010 1",
                           q[0].d, q[0].m, q[0].l);
      end
    end
    send(9, 16'h98, 1);
    idle(3);
    checks++;
    if (q.size() != 1 || drop_cnt_o !== d0 + 16'd2) begin
      errors++; $display("FAIL drop_lone outputs=%0d drop=%0d expected 1 and %0d", q.size(), drop_cnt_o, d0 + 2);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0][DW-1:0] sd;
    logic [N-1:0]         sm;
    int                   bad = 0;
    q.delete();
    rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) send(TW'(i), DW'(16'hB0 + i), 0);
    vld_i = 1'b1; tag_i = 0; data_i = 16'h77; tlast_i = 1'b1;
    #1;
    sd = data_o; sm = mask_o;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (vld_o !== 1'b1 || data_o !== sd || mask_o !== sm || rdy_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold unstable or ready in %0d of 5 cycles expected 0", bad); end
    rdy_i = 1'b1;
    @(negedge clk);
    vld_i = 1'b0; tlast_i = 1'b0;
    idle(3);
    checks++;
    if (q.size() != 2) begin errors++; $display("FAIL bp_count got %0d expected 2", q.size()); end
    else begin
      checks++;
      if (q[0].d !== {16'hB3, 16'hB2, 16'hB1, 16'hB0} || q[0].m !== 4'b1111 || q[0].l !== 1'b0) begin
        errors++; $display("FAIL bp_first data=%h mask=%b last=%b expected 00b300b200b100b0 1111 0",
                           q[0].d, q[0].m, q[0].l);
      end
      checks++;
      if (q[1].d !== {16'h0, 16'h0, 16'h0, 16'h77} || q[1].m !== 4'b0001 || q[1].l !== 1'b1) begin
        errors++; $display("FAIL bp_second data=%h mask=%b last=%b expected 0000000000000077 0001 1",
                           q[1].d, q[1].m, q[1].l);
      end
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    send(0, 16'hC0, 0); send(1, 16'hC1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(2, 16'hC2, 0); send(3, 16'hC3, 1);
    idle(3);
    checks++;
    if (q.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d expected 1", q.size()); end
    else begin
      checks++;
      if (q[0].d !== {16'hC3, 16'hC2, 16'h0, 16'h0} || q[0].m !== 4'b1100 || q[0].l !== 1'b1) begin
        errors++; $display("FAIL rstmid_data data=%h mask=%b last=%b expected 00c300c200000000 1100 1",
                           q[0].d, q[0].m, q[0].l);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_four_beats();
    test_collision();
    test_collision_last();
    test_drop();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
